// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: producer handshakes, regfile write port and forwarding queries
// of the write-back queue. The queue itself is the slave side.
interface regfile_wb_queue_if #(
    parameter int width = 32,
    parameter int DEPTH = 4
);
    logic                     a_valid;
    logic                     a_ready;
    logic [4:0]               a_addr;
    logic [width-1:0]         a_data;
    logic                     b_valid;
    logic                     b_ready;
    logic [4:0]               b_addr;
    logic [width-1:0]         b_data;
    logic [4:0]               W_addr;
    logic [width-1:0]         W_data;
    logic                     wr_enable;
    logic [4:0]               A_addr;
    logic [4:0]               B_addr;
    logic                     A_fwd_valid;
    logic [width-1:0]         A_fwd_data;
    logic                     B_fwd_valid;
    logic [width-1:0]         B_fwd_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, A_addr, B_addr,
        input  a_ready, b_ready, W_addr, W_data, wr_enable,
               A_fwd_valid, A_fwd_data, B_fwd_valid, B_fwd_data, count
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, A_addr, B_addr,
        output a_ready, b_ready, W_addr, W_data, wr_enable,
               A_fwd_valid, A_fwd_data, B_fwd_valid, B_fwd_data, count
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back queue fed by two producers, draining one entry
// per cycle to the regfile write port, with youngest-match forwarding for two read ports.
module regfile_wb_queue #(
    parameter int width = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]       r_addr [DEPTH];
    logic [width-1:0] r_data [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    logic             w_push_a;
    logic             w_push_b;
    logic             w_pop;
    logic [AW-1:0]    w_tail_b;

    // Ready depends only on the registered count, so B's stricter limit guarantees
    // room for a simultaneous A and B push even when nothing pops.
    assign bus.a_ready = reset && (r_count < (AW+1)'(DEPTH));
    assign bus.b_ready = reset && (r_count <= (AW+1)'(DEPTH-2));

    assign w_push_a = bus.a_valid && bus.a_ready && (bus.a_addr != 5'd0);
    assign w_push_b = bus.b_valid && bus.b_ready && (bus.b_addr != 5'd0);
    assign w_pop    = (r_count != '0);
    assign w_tail_b = r_tail + AW'(w_push_a);

    assign bus.wr_enable = w_pop;
    assign bus.W_addr    = w_pop ? r_addr[r_head] : 5'd0;
    assign bus.W_data    = w_pop ? r_data[r_head] : '0;
    assign bus.count     = r_count;

    // Walk oldest to youngest so the last hit is the youngest pending write.
    function automatic logic [width:0] fwd(input logic [4:0] q);
        logic [width:0] res = '0;
        logic [AW-1:0]  idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + AW'(i);
            if (q != 5'd0 && (AW+1)'(i) < r_count && r_addr[idx] == q)
                res = {1'b1, r_data[idx]};
        end
        return res;
    endfunction

    assign {bus.A_fwd_valid, bus.A_fwd_data} = fwd(bus.A_addr);
    assign {bus.B_fwd_valid, bus.B_fwd_data} = fwd(bus.B_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= w_tail_b + AW'(w_push_b);
            r_count <= r_count - (AW+1)'(w_pop) + (AW+1)'(w_push_a) + (AW+1)'(w_push_b);
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_addr[r_tail] <= bus.a_addr;
            r_data[r_tail] <= bus.a_data;
        end
        if (w_push_b) begin
            r_addr[w_tail_b] <= bus.b_addr;
            r_data[w_tail_b] <= bus.b_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed checks of the write-back queue, including a
// scoreboarded back-to-back producer run and asynchronous reset mid-operation.
module tb_regfile_wb_queue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    regfile_wb_queue_if #(.width(32), .DEPTH(4)) bus ();
    regfile_wb_queue #(.width(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_addr  = ad;
        bus.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_addr  = ad;
        bus.b_data  = d;
    endtask

    logic [36:0] sb[$];
    int          mc;
    int          na;
    int          nb;
    logic        ra;
    logic        rb;

    initial begin
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        bus.A_addr = 5'd0;
        bus.B_addr = 5'd0;
        #3;
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_wr_en", bus.wr_enable, 0);
        chk("rst_count", bus.count, 0);
        @(negedge clk);
        reset = 1'b1;
        step;
        chk("idle_count", bus.count, 0);
        chk("idle_wr_en", bus.wr_enable, 0);
        chk("idle_a_ready", bus.a_ready, 1);
        chk("idle_b_ready", bus.b_ready, 1);

        // single A push, written on the following edge
        drive_a(1'b1, 5'd5, 32'h11);
        bus.A_addr = 5'd5;
        step;
        drive_a(1'b0, 5'd0, 32'h0);
        chk("one_count", bus.count, 1);
        chk("one_wr_en", bus.wr_enable, 1);
        chk("one_W_addr", bus.W_addr, 5);
        chk("one_W_data", bus.W_data, 32'h11);
        chk("one_fwd_v", bus.A_fwd_valid, 1);
        chk("one_fwd_d", bus.A_fwd_data, 32'h11);
        step;
        chk("one_drained", bus.count, 0);
        chk("one_wr_off", bus.wr_enable, 0);
        chk("one_W_zero", bus.W_addr, 0);
        chk("one_fwd_off", bus.A_fwd_valid, 0);

        // same-cycle A and B to the same register: A older, youngest forwards
        drive_a(1'b1, 5'd3, 32'hA);
        drive_b(1'b1, 5'd3, 32'hB);
        bus.A_addr = 5'd3;
        bus.B_addr = 5'd7;
        step;
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        chk("ab_count", bus.count, 2);
        chk("ab_W_addr0", bus.W_addr, 3);
        chk("ab_W_data0", bus.W_data, 32'hA);
        chk("ab_fwd_v", bus.A_fwd_valid, 1);
        chk("ab_fwd_d", bus.A_fwd_data, 32'hB);
        chk("ab_miss_v", bus.B_fwd_valid, 0);
        chk("ab_miss_d", bus.B_fwd_data, 0);
        step;
        chk("ab_count1", bus.count, 1);
        chk("ab_W_data1", bus.W_data, 32'hB);
        chk("ab_fwd_d1", bus.A_fwd_data, 32'hB);
        step;
        chk("ab_count0", bus.count, 0);
        chk("ab_fwd_v0", bus.A_fwd_valid, 0);
        chk("ab_fwd_d0", bus.A_fwd_data, 0);

        // address 0 completes the handshake but is never queued
        drive_a(1'b1, 5'd0, 32'hFF);
        bus.A_addr = 5'd0;
        chk("z_a_ready", bus.a_ready, 1);
        step;
        drive_a(1'b0, 5'd0, 32'h0);
        chk("z_count", bus.count, 0);
        chk("z_wr_en", bus.wr_enable, 0);
        chk("z_fwd_q0", bus.A_fwd_valid, 0);

        // both producers held valid; every accepted entry drained once, in order
        mc = 0;
        na = 0;
        nb = 0;
        for (int c = 0; c < 14; c++) begin
            drive_a(1'b1, 5'(na % 31 + 1), 32'hA000_0000 + 32'(na));
            drive_b(1'b1, (nb % 4 == 3) ? 5'd0 : 5'(nb % 31 + 1), 32'hB000_0000 + 32'(nb));
            #1;
            ra = (mc < 4);
            rb = (mc <= 2);
            chk("run_a_ready", bus.a_ready, 64'(ra));
            chk("run_b_ready", bus.b_ready, 64'(rb));
            step;
            if (sb.size() != 0) void'(sb.pop_front());
            if (ra) begin
                if (bus.a_addr != 5'd0) sb.push_back({bus.a_addr, bus.a_data});
                na++;
            end
            if (rb) begin
                if (bus.b_addr != 5'd0) sb.push_back({bus.b_addr, bus.b_data});
                nb++;
            end
            mc = sb.size();
            chk("run_count", bus.count, 64'(mc));
            chk("run_wr_en", bus.wr_enable, 64'(mc != 0));
            if (mc != 0) chk("run_W", {bus.W_addr, bus.W_data}, 64'(sb[0]));
        end
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        for (int c = 0; c < 6 && sb.size() != 0; c++) begin
            step;
            void'(sb.pop_front());
            mc = sb.size();
            chk("drain_count", bus.count, 64'(mc));
            if (mc != 0) chk("drain_W", {bus.W_addr, bus.W_data}, 64'(sb[0]));
        end
        chk("drain_empty", bus.wr_enable, 0);

        // fill three entries, then reset asynchronously mid-cycle
        drive_a(1'b1, 5'd1, 32'hD1);
        drive_b(1'b1, 5'd2, 32'hD2);
        step;
        drive_a(1'b1, 5'd3, 32'hD3);
        drive_b(1'b1, 5'd4, 32'hD4);
        bus.A_addr = 5'd4;
        step;
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        chk("fill_count", bus.count, 3);
        chk("fill_W_addr", bus.W_addr, 2);
        chk("fill_fwd_d", bus.A_fwd_data, 32'hD4);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count", bus.count, 0);
        chk("ar_wr_en", bus.wr_enable, 0);
        chk("ar_fwd_v", bus.A_fwd_valid, 0);
        chk("ar_a_ready", bus.a_ready, 0);
        step;
        chk("ar_hold_wr", bus.wr_enable, 0);
        @(negedge clk);
        reset = 1'b1;
        step;
        chk("ar_rel_count", bus.count, 0);
        chk("ar_rel_wr", bus.wr_enable, 0);
        chk("ar_rel_fwd", bus.A_fwd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
